// File: rtl/bp_be_pkg.sv
// Shared types for the FE-to-BE pair packer: FE queue entry layout,
// processor configuration selector, and the packer state encoding.
// Width helpers are evaluated at elaboration time only.
package bp_be_pkg;

  typedef enum logic {e_bp_default_cfg} bp_params_e;

  localparam int vaddr_width_gp = 39;
  localparam int instr_width_gp = 32;

  typedef enum logic [1:0] {
    e_instr_fetch = 2'b00,
    e_exception   = 2'b01,
    e_icache_miss = 2'b10,
    e_itlb_miss   = 2'b11
  } bp_fe_msg_type_e;

  typedef struct packed {
    bp_fe_msg_type_e             msg_type;
    logic [vaddr_width_gp-1:0]   pc;
    logic [instr_width_gp-1:0]   instr;
  } bp_fe_queue_s;

  typedef enum logic [1:0] {e_empty, e_half, e_solo} bp_be_pair_state_e;

  // Only the default configuration exists; anything else yields width 0.
  function automatic int fe_queue_width_f(bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? $bits(bp_fe_queue_s) : 0;
  endfunction

  // Only instruction-fetch entries may share an issue slot pair.
  function automatic logic is_pairable(bp_fe_queue_s e);
    return (e.msg_type == e_instr_fetch);
  endfunction

endpackage

// File: rtl/bp_be_fe_pair_packer.sv
// Packs consecutive FE fetch entries into ordered {older, younger} pairs for the BE issue queue.
// Latency: one cycle from the completing input (or the timeout/solo flush) to the pair register.
// Backpressure: intake stalls when the pair register is full and not draining, or while a solo entry waits.
module bp_be_fe_pair_packer
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int timeout_p = 2,
  localparam int fe_queue_width_lp = fe_queue_width_f(bp_params_p),
  localparam int age_width_lp = (timeout_p + 1 > 2) ? $clog2(timeout_p + 1) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clr_v_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0] fe_queue1_o,
  output logic [fe_queue_width_lp-1:0] fe_queue2_o,
  output logic                         fe_queue_v1_o,
  output logic                         fe_queue_v2_o,
  input  logic                         fe_queue_ready_i
);

  localparam logic [age_width_lp-1:0] age_last_lp = age_width_lp'(timeout_p - 1);

  bp_be_pair_state_e            state_r, state_n;
  logic [age_width_lp-1:0]      age_r, age_n;
  logic [fe_queue_width_lp-1:0] hold_r, hold_n;
  logic [fe_queue_width_lp-1:0] out1_r, out2_r, out1_n, out2_n;
  logic                         outv1_r, outv2_r, outv2_n;
  logic                         load_out;

  logic slot_avail, accept, transfer, pairable;

  // The pair register may be (re)loaded when empty or when its contents leave this cycle.
  assign slot_avail       = ~outv1_r | fe_queue_ready_i;
  assign fe_queue_ready_o = ~reset_i & ~clr_v_i & slot_avail & (state_r != e_solo);
  assign accept           = fe_queue_ready_o & fe_queue_v_i;
  assign transfer         = outv1_r & fe_queue_ready_i;
  assign pairable         = is_pairable(bp_fe_queue_s'(fe_queue_i));

  // Next-state decode: decide what (if anything) lands in the pair register.
  always_comb begin
    state_n  = state_r;
    age_n    = age_r;
    hold_n   = hold_r;
    load_out = 1'b0;
    out1_n   = out1_r;
    out2_n   = out2_r;
    outv2_n  = 1'b0;
    unique case (state_r)
      e_empty: begin
        if (accept && pairable) begin
          hold_n  = fe_queue_i;
          age_n   = '0;
          state_n = e_half;
        end else if (accept) begin
          load_out = 1'b1;
          out1_n   = fe_queue_i;
          out2_n   = '0;
        end
      end
      e_half: begin
        if (accept && pairable) begin
          load_out = 1'b1;
          out1_n   = hold_r;
          out2_n   = fe_queue_i;
          outv2_n  = 1'b1;
          state_n  = e_empty;
        end else if (accept) begin
          // Held fetch goes out alone; the non-fetch entry waits its own turn.
          load_out = 1'b1;
          out1_n   = hold_r;
          out2_n   = '0;
          hold_n   = fe_queue_i;
          state_n  = e_solo;
        end else if (age_r == age_last_lp && slot_avail) begin
          load_out = 1'b1;
          out1_n   = hold_r;
          out2_n   = '0;
          state_n  = e_empty;
        end else if (age_r != age_last_lp) begin
          age_n = age_r + age_width_lp'(1);
        end
      end
      e_solo: begin
        if (slot_avail) begin
          load_out = 1'b1;
          out1_n   = hold_r;
          out2_n   = '0;
          state_n  = e_empty;
        end
      end
      default: state_n = e_empty;
    endcase
  end

  // All packer state; a director flush wins over any intake or transfer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_empty;
      age_r   <= '0;
      hold_r  <= '0;
      out1_r  <= '0;
      out2_r  <= '0;
      outv1_r <= 1'b0;
      outv2_r <= 1'b0;
    end else if (clr_v_i) begin
      state_r <= e_empty;
      age_r   <= '0;
      outv1_r <= 1'b0;
      outv2_r <= 1'b0;
    end else begin
      state_r <= state_n;
      age_r   <= age_n;
      hold_r  <= hold_n;
      if (load_out) begin
        out1_r  <= out1_n;
        out2_r  <= out2_n;
        outv1_r <= 1'b1;
        outv2_r <= outv2_n;
      end else if (transfer) begin
        outv1_r <= 1'b0;
        outv2_r <= 1'b0;
      end
    end
  end

  assign fe_queue1_o   = out1_r;
  assign fe_queue2_o   = out2_r;
  assign fe_queue_v1_o = outv1_r;
  assign fe_queue_v2_o = outv2_r;

endmodule

// File: tb/tb_bp_be_fe_pair_packer.sv
// Directed bench for the FE pair packer: pairing, timeout flush, solo handling,
// back-pressure, director flush and asynchronous reset, with hand-computed expectations.
module tb_bp_be_fe_pair_packer;
  import bp_be_pkg::*;

  localparam int W = fe_queue_width_f(e_bp_default_cfg);
  localparam int OW = 2 * W + 2;

  logic         clk;
  logic         reset_i;
  logic         clr_v_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i;
  logic         fe_queue_ready_o;
  logic [W-1:0] fe_queue1_o;
  logic [W-1:0] fe_queue2_o;
  logic         fe_queue_v1_o;
  logic         fe_queue_v2_o;
  logic         fe_queue_ready_i;

  int checks;
  int fails;

  logic [W-1:0] ea, eb, ec, ed, ee, ef, ex, ey;
  logic [W-1:0] zero_e;

  bp_be_fe_pair_packer #(.bp_params_p(e_bp_default_cfg), .timeout_p(2)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .clr_v_i         (clr_v_i),
    .fe_queue_i      (fe_queue_i),
    .fe_queue_v_i    (fe_queue_v_i),
    .fe_queue_ready_o(fe_queue_ready_o),
    .fe_queue1_o     (fe_queue1_o),
    .fe_queue2_o     (fe_queue2_o),
    .fe_queue_v1_o   (fe_queue_v1_o),
    .fe_queue_v2_o   (fe_queue_v2_o),
    .fe_queue_ready_i(fe_queue_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(bp_fe_msg_type_e t, logic [31:0] n);
    bp_fe_queue_s e;
    e.msg_type = t;
    e.pc       = vaddr_width_gp'(n);
    e.instr    = ~n;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o} !== {2'b00, zero_e, zero_e}) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o}, {2'b00, zero_e, zero_e});
    end
    checks++;
    if (fe_queue_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 0", fe_queue_ready_o);
    end
    step();
    step();
    reset_i = 1'b0;
    #1;
    checks++;
    if (fe_queue_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b expected 1", fe_queue_ready_o);
    end
  endtask

  task automatic test_pairing();
    fe_queue_i = ea; fe_queue_v_i = 1'b1;
    #1;
    checks++;
    if (fe_queue_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL pair_ready: got %b expected 1", fe_queue_ready_o);
    end
    step();
    fe_queue_i = eb;
    step();
    fe_queue_v_i = 1'b0;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o} !== {2'b11, ea, eb}) begin
      fails++;
      $display("FAIL pair_out: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o}, {2'b11, ea, eb});
    end
    step();
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o} !== 2'b00) begin
      fails++;
      $display("FAIL pair_drain: got %b expected 00", {fe_queue_v1_o, fe_queue_v2_o});
    end
  endtask

  task automatic test_timeout();
    fe_queue_i = ea; fe_queue_v_i = 1'b1;
    step();
    fe_queue_v_i = 1'b0;
    #1;
    checks++;
    if ({fe_queue_v1_o, fe_queue_ready_o} !== 2'b01) begin
      fails++;
      $display("FAIL timeout_c1: got v1/ready %b expected 01", {fe_queue_v1_o, fe_queue_ready_o});
    end
    step();
    checks++;
    if (fe_queue_v1_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_c2: got v1 %b expected 0", fe_queue_v1_o);
    end
    step();
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o} !== {2'b10, ea}) begin
      fails++;
      $display("FAIL timeout_c3: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o}, {2'b10, ea});
    end
    // A fresh pair must not be merged with the already flushed entry.
    fe_queue_i = ee; fe_queue_v_i = 1'b1;
    step();
    fe_queue_i = ef;
    step();
    fe_queue_v_i = 1'b0;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o} !== {2'b11, ee, ef}) begin
      fails++;
      $display("FAIL timeout_then_pair: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o}, {2'b11, ee, ef});
    end
    step();
  endtask

  task automatic test_solo_after_half();
    // Non-fetch from empty goes straight out alone.
    fe_queue_i = ey; fe_queue_v_i = 1'b1;
    step();
    fe_queue_v_i = 1'b0;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o} !== {2'b10, ey}) begin
      fails++;
      $display("FAIL solo_from_empty: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o}, {2'b10, ey});
    end
    step();
    fe_queue_i = ea; fe_queue_v_i = 1'b1;
    step();
    fe_queue_i = ex;
    #1;
    checks++;
    if (fe_queue_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL solo_accept_ready: got %b expected 1", fe_queue_ready_o);
    end
    step();
    fe_queue_v_i = 1'b0;
    #1;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue_ready_o} !== {2'b10, ea, 1'b0}) begin
      fails++;
      $display("FAIL solo_half_flush: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue_ready_o}, {2'b10, ea, 1'b0});
    end
    step();
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o} !== {2'b10, ex}) begin
      fails++;
      $display("FAIL solo_exception_out: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o}, {2'b10, ex});
    end
    step();
    checks++;
    if (fe_queue_v1_o !== 1'b0) begin
      fails++;
      $display("FAIL solo_drain: got %b expected 0", fe_queue_v1_o);
    end
  endtask

  task automatic test_back_to_back();
    fe_queue_v_i = 1'b1;
    fe_queue_i = ea; step();
    fe_queue_i = eb; step();
    fe_queue_i = ec; #1;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o, fe_queue_ready_o} !== {2'b11, ea, eb, 1'b1}) begin
      fails++;
      $display("FAIL b2b_first: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o, fe_queue_ready_o}, {2'b11, ea, eb, 1'b1});
    end
    step();
    fe_queue_i = ed;
    checks++;
    if (fe_queue_v1_o !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap: got v1 %b expected 0", fe_queue_v1_o);
    end
    step();
    fe_queue_v_i = 1'b0;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o} !== {2'b11, ec, ed}) begin
      fails++;
      $display("FAIL b2b_second: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o}, {2'b11, ec, ed});
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] exp_ab;
    exp_ab = {2'b11, ea, eb};
    fe_queue_v_i = 1'b1;
    fe_queue_i = ea; step();
    fe_queue_i = eb; step();
    fe_queue_ready_i = 1'b0;
    fe_queue_i = ec;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o} !== exp_ab || fe_queue_ready_o !== 1'b0) begin
        fails++;
        $display("FAIL bp_stall_%0d: got out %h ready %b expected %h ready 0", i, {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o}, fe_queue_ready_o, exp_ab);
      end
      step();
    end
    fe_queue_ready_i = 1'b1;
    #1;
    checks++;
    if (fe_queue_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: got %b expected 1", fe_queue_ready_o);
    end
    step();
    fe_queue_i = ed;
    step();
    fe_queue_v_i = 1'b0;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o} !== {2'b11, ec, ed}) begin
      fails++;
      $display("FAIL bp_next_pair: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o}, {2'b11, ec, ed});
    end
    step();
  endtask

  task automatic test_flush();
    fe_queue_i = ea; fe_queue_v_i = 1'b1;
    step();
    clr_v_i = 1'b1;
    fe_queue_i = eb;
    #1;
    checks++;
    if (fe_queue_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_ready: got %b expected 0", fe_queue_ready_o);
    end
    step();
    clr_v_i = 1'b0; fe_queue_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({fe_queue_v1_o, fe_queue_v2_o} !== 2'b00) begin
        fails++;
        $display("FAIL flush_no_emit_%0d: got %b expected 00", i, {fe_queue_v1_o, fe_queue_v2_o});
      end
      step();
    end
    // Flush also discards a pair stuck behind a stalled issue queue.
    fe_queue_v_i = 1'b1;
    fe_queue_i = ec; step();
    fe_queue_i = ed; step();
    fe_queue_v_i = 1'b0; fe_queue_ready_i = 1'b0; clr_v_i = 1'b1;
    step();
    clr_v_i = 1'b0;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o} !== 2'b00) begin
      fails++;
      $display("FAIL flush_stuck_pair: got %b expected 00", {fe_queue_v1_o, fe_queue_v2_o});
    end
    fe_queue_ready_i = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    fe_queue_v_i = 1'b1;
    fe_queue_i = ea; step();
    fe_queue_i = eb; step();
    fe_queue_v_i = 1'b0; fe_queue_ready_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o, fe_queue_ready_o} !== {2'b00, zero_e, zero_e, 1'b0}) begin
      fails++;
      $display("FAIL arst_pair: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o, fe_queue_ready_o}, {2'b00, zero_e, zero_e, 1'b0});
    end
    #1;
    reset_i = 1'b0; fe_queue_ready_i = 1'b1;
    step();
    fe_queue_i = ec; fe_queue_v_i = 1'b1;
    step();
    fe_queue_v_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if ({fe_queue_ready_o, fe_queue_v1_o} !== 2'b00) begin
      fails++;
      $display("FAIL arst_half: got ready/v1 %b expected 00", {fe_queue_ready_o, fe_queue_v1_o});
    end
    #1;
    reset_i = 1'b0;
    step();
    fe_queue_v_i = 1'b1;
    fe_queue_i = ee; step();
    fe_queue_i = ef; step();
    fe_queue_v_i = 1'b0;
    checks++;
    if ({fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o} !== {2'b11, ee, ef}) begin
      fails++;
      $display("FAIL arst_repack: got %h expected %h", {fe_queue_v1_o, fe_queue_v2_o, fe_queue1_o, fe_queue2_o}, {2'b11, ee, ef});
    end
    step();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    zero_e = '0;
    ea = mk(e_instr_fetch, 32'h0000_1000);
    eb = mk(e_instr_fetch, 32'h0000_1004);
    ec = mk(e_instr_fetch, 32'h0000_1008);
    ed = mk(e_instr_fetch, 32'h0000_100c);
    ee = mk(e_instr_fetch, 32'h0000_2000);
    ef = mk(e_instr_fetch, 32'h0000_2004);
    ex = mk(e_exception,   32'h0000_1004);
    ey = mk(e_itlb_miss,   32'h0000_3000);
    reset_i          = 1'b1;
    clr_v_i          = 1'b0;
    fe_queue_i       = '0;
    fe_queue_v_i     = 1'b0;
    fe_queue_ready_i = 1'b1;

    test_reset();
    test_pairing();
    test_timeout();
    test_solo_after_half();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
